// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch states, instruction field widths, reset vector.
// Pure declarations; no timing or flow control of its own.
// Backpressure: not applicable.
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNC_W  = 6;
    localparam int IMM_W   = 16;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_split.sv
// Splits a MIPS instruction word into its R/I-type fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure slicing.
module instr_split
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]    ir,
    output logic [OP_W-1:0]    upcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [SHAMT_W-1:0] shamt,
    output logic [FUNC_W-1:0]  func,
    output logic [IMM_W-1:0]   imm
);

    assign upcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign func   = ir[5:0];
    assign imm    = ir[15:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from imem, holds one decoded instruction for the control FSM.
// Latency: one cycle from imem_ack to instr_valid; two cycles minimum per instruction.
// Backpressure: instr_ready low holds the instruction and suppresses further requests.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [XLEN-1:0]    instr_pc,
    output logic [OP_W-1:0]    upcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [SHAMT_W-1:0] shamt,
    output logic [FUNC_W-1:0]  func,
    output logic [IMM_W-1:0]   imm
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pending_pc, pending_pc_nxt;
    logic [XLEN-1:0] ir, ir_nxt;
    logic [XLEN-1:0] ipc, ipc_nxt;
    logic [XLEN-1:0] target;

    assign target = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= word_align(RESET_PC);
            pending_pc <= '0;
            ir         <= '0;
            ipc        <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_pc_nxt;
            ir         <= ir_nxt;
            ipc        <= ipc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pending_pc_nxt = pending_pc;
        ir_nxt         = ir;
        ipc_nxt        = ipc;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect_valid) pc_nxt = target;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_nxt = target;
                    end else begin
                        ir_nxt    = imem_rdata;
                        ipc_nxt   = pc;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The bus request cannot be withdrawn, so park the target until it completes.
                    pending_pc_nxt = target;
                    state_nxt      = FLUSH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    pc_nxt    = redirect_valid ? target : pending_pc;
                    state_nxt = FETCH;
                end else if (redirect_valid) begin
                    pending_pc_nxt = target;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pc only advances on ack, so the address is stable for the whole request.
    assign imem_req    = (state == FETCH) || (state == FLUSH);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state == HOLD);
    assign instr_pc    = ipc;

    instr_split u_split (
        .ir     (ir),
        .upcode (upcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .func   (func),
        .imm    (imm)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch sequencing, hold, redirects, wrap and reset abort.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [5:0]  upcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  func;
    logic [15:0] imm;

    logic        alt_req;
    logic [31:0] alt_addr;
    logic        alt_valid;
    logic [31:0] alt_ipc;
    logic [5:0]  alt_upcode;
    logic [4:0]  alt_rs, alt_rt, alt_rd, alt_shamt;
    logic [5:0]  alt_func;
    logic [15:0] alt_imm;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
        .upcode(upcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm)
    );

    // Unaligned reset vector: low bits must be dropped.
    instr_fetch #(.RESET_PC(32'h0000_1003)) alt (
        .clk(clk), .rst(rst),
        .imem_req(alt_req), .imem_addr(alt_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(alt_valid), .instr_ready(instr_ready), .instr_pc(alt_ipc),
        .upcode(alt_upcode), .rs(alt_rs), .rt(alt_rt), .rd(alt_rd), .shamt(alt_shamt),
        .func(alt_func), .imm(alt_imm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic req, input logic [31:0] addr, input logic vld);
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] pc, input logic [5:0] e_up,
                              input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [4:0] e_rd,
                              input logic [4:0] e_sh, input logic [5:0] e_fn, input logic [15:0] e_imm);
        chk({tag, ".pc"},    instr_pc,          pc);
        chk({tag, ".up"},    {26'd0, upcode},   {26'd0, e_up});
        chk({tag, ".rs"},    {27'd0, rs},       {27'd0, e_rs});
        chk({tag, ".rt"},    {27'd0, rt},       {27'd0, e_rt});
        chk({tag, ".rd"},    {27'd0, rd},       {27'd0, e_rd});
        chk({tag, ".shamt"}, {27'd0, shamt},    {27'd0, e_sh});
        chk({tag, ".func"},  {26'd0, func},     {26'd0, e_fn});
        chk({tag, ".imm"},   {16'd0, imm},      {16'd0, e_imm});
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

        #2;
        chk_if("reset", 1'b0, 32'h0, 1'b0);
        chk_fields("reset", 32'h0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
        #10;
        rst = 1'b0;                     // released at t=12, between edges
        #1;
        chk_if("idle", 1'b0, 32'h0, 1'b0);

        // First fetch at 0x0, zero-wait ack with add $t2,$t2,$t1.
        step();
        chk_if("fetch0", 1'b1, 32'h0, 1'b0);
        chk("alt_reset_addr", alt_addr, 32'h0000_1000);
        imem_ack = 1'b1; imem_rdata = 32'h0149_5020;
        step();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        chk_if("hold0", 1'b0, 32'h0, 1'b1);
        chk_fields("add", 32'h0, 6'd0, 5'd10, 5'd9, 5'd10, 5'd0, 6'h20, 16'h5020);

        // Second fetch two cycles after the first; lw $t0,16($a1), then stall the consumer.
        step();
        chk_if("fetch4", 1'b1, 32'h4, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'h8CA8_0010; instr_ready = 1'b0;
        step();
        imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk_if($sformatf("stall%0d", i), 1'b0, 32'h0, 1'b1);
            chk_fields($sformatf("stall%0d", i), 32'h4, 6'h23, 5'd5, 5'd8, 5'd0, 5'd0, 6'h10, 16'h0010);
            step();
        end
        chk_if("stall_end", 1'b0, 32'h0, 1'b1);
        instr_ready = 1'b1;
        step();
        chk_if("fetch8", 1'b1, 32'h8, 1'b0);

        // Redirect while 0x8 waits three cycles for ack; target low bits ignored.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk_if("flush_a", 1'b1, 32'h8, 1'b0);
        step();
        chk_if("flush_b", 1'b1, 32'h8, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        chk_if("after_flush", 1'b1, 32'h100, 1'b0);

        // Redirect coincident with ack: data dropped, no valid.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        chk_if("redir_ack", 1'b1, 32'h200, 1'b0);
        redirect_pc = 32'hFFFF_FFFC;
        step();
        chk_if("to_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
        redirect_valid = 1'b0; imem_rdata = 32'h0000_0000;
        step();
        imem_ack = 1'b0;
        chk_if("hold_top", 1'b0, 32'h0, 1'b1);
        chk("hold_top.pc", instr_pc, 32'hFFFF_FFFC);
        step();
        chk_if("wrap", 1'b1, 32'h0, 1'b0);

        // Redirect during HOLD with ready low.
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk_if("hold_r", 1'b0, 32'h0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        chk_if("hold_redir", 1'b1, 32'h40, 1'b0);

        // FLUSH: last redirect wins; ack alone takes pending target.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0400;
        chk_if("fl1", 1'b1, 32'h40, 1'b0);
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        chk_if("fl2", 1'b1, 32'h40, 1'b0);
        step();
        imem_ack = 1'b0;
        chk_if("fl_pending", 1'b1, 32'h400, 1'b0);

        // FLUSH: redirect coincident with ack overrides pending.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0600;
        step();
        imem_ack = 1'b1; redirect_pc = 32'h0000_0700;
        chk_if("fl3", 1'b1, 32'h400, 1'b0);
        step();
        imem_ack = 1'b0;
        chk_if("fl_coinc", 1'b1, 32'h700, 1'b0);

        // Reset pulse during FLUSH, with a late ack lingering across release.
        redirect_pc = 32'h0000_0800;
        step();
        redirect_valid = 1'b0;
        chk_if("fl4", 1'b1, 32'h700, 1'b0);
        #2;
        rst = 1'b1; imem_ack = 1'b1;
        #1;
        chk_if("rst_async", 1'b0, 32'h0, 1'b0);
        chk_fields("rst_async", 32'h0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_if("rst_idle", 1'b0, 32'h0, 1'b0);
        imem_ack = 1'b0;
        step();
        chk_if("rst_fetch", 1'b1, 32'h0, 1'b0);
        chk("alt_rst_fetch", alt_addr, 32'h0000_1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  byte address of requested word; bits [1:0] always 0.
REQ-006 imem_ack  input  1  memory accepts request; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 redirect_valid  input  1  branch/jump redirect from the control FSM.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-010 instr_valid  output  1  decoded instruction fields valid for the control FSM.
REQ-011 instr_ready  input  1  control FSM consumes the held instruction.
REQ-012 instr_pc  output  32  address of the held instruction.
REQ-013 upcode/rs/rt/rd/shamt/func/imm  output  6/5/5/5/5/6/16  fields of the held instruction.

Function
REQ-014 States SHALL be IDLE, FETCH, HOLD, FLUSH.
REQ-015 IDLE: imem_req=0; unconditional transition to FETCH on the next edge.
REQ-016 FETCH: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay constant until the cycle imem_ack=1.
REQ-017 FETCH with imem_ack=1 and no redirect: capture imem_rdata into IR, instr_pc=pc, pc=pc+4, go HOLD; instr_valid=1 and imem_req=0 from the next cycle.
REQ-018 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 HOLD: instr_valid=1; all field outputs and instr_pc SHALL remain stable until instr_ready=1.
REQ-020 HOLD with instr_ready=1: go FETCH; instr_valid=0 and imem_req=1 next cycle (minimum 2 cycles per instruction with zero-wait memory).
REQ-021 Field slicing: upcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], shamt=IR[10:6], func=IR[5:0], imm=IR[15:0].
REQ-022 Redirect in HOLD (with or without instr_ready): held instruction retired, pc={redirect_pc[31:2],2'b00}, go FETCH; instr_valid=0 next cycle.
REQ-023 Redirect in FETCH with imem_ack=1 same cycle: discard imem_rdata, pc=redirect target, go FETCH (new request next cycle).
REQ-024 Redirect in FETCH with imem_ack=0: latch target into pending_pc, go FLUSH; outstanding request continues unchanged.
REQ-025 FLUSH: imem_req=1 with original address; on imem_ack discard data, pc=pending_pc, go FETCH; a further redirect in FLUSH overwrites pending_pc (last wins; if coincident with ack, the new target is used).
REQ-026 Redirect in IDLE: pc=redirect target, go FETCH.
REQ-027 instr_valid SHALL never be 1 in IDLE, FETCH or FLUSH.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, pc=RESET_PC, pending_pc=0, IR=0, instr_pc=0, imem_req=0, instr_valid=0, all field outputs 0.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_ack after reset SHALL be ignored while not in FETCH/FLUSH.

Structure
REQ-030 State enum, opcode field widths and RESET_PC default SHALL live in shared package mips_pkg, also used by the control FSM.
REQ-031 Field slicing SHALL be a combinational sub-module instr_split (IR in, seven fields out).

Verification
REQ-032 Reset release, RESET_PC=0, zero-wait ack, ready always 1 -> imem_addr 0x0,0x4,0x8 on consecutive requests two cycles apart.
REQ-033 imem_rdata=32'h0149_5020 (add $t2,$t2,$t1) -> upcode=0, rs=10, rt=9, rd=10, shamt=0, func=6'h20 while instr_valid=1.
REQ-034 instr_ready held 0 for 5 cycles in HOLD -> all outputs stable, imem_req=0, no address advance.
REQ-035 Redirect to 0x100 while request to 0x8 waits 3 cycles for ack -> imem_addr stays 0x8 until ack, data discarded, next request 0x100.
REQ-036 Redirect 0x200 coincident with ack -> no instr_valid, next request 0x200; pc=0xFFFF_FFFC fetch -> next request 0x0.
REQ-037 rst pulsed during FLUSH -> all outputs zero immediately, next request at RESET_PC.
